// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave front-end.
//   state_e : frame FSM states (3-bit, binary-encoded)
//   OP_*    : 2-bit command opcodes carried in the top bits of each frame
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        TX_WAIT   = 3'd5,
        TX_SHIFT  = 3'd6,
        DONE      = 3'd7
    } state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_param_tx.sv
// spi_tx_serializer: parallel-load, MSB-first serialiser for the read word.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : capture data_i; MSB appears on miso_o after this edge
//   shift_i    : drive the next bit on miso_o
//   clear_i    : force miso_o low and idle the counter
//   data_i     : DATA_W-bit word to send
//   miso_o     : registered serial output
//   done_o     : all DATA_W bits have been driven
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              done_o
);
    import spi_slave_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q,   sr_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              miso_q, miso_d;

    // cnt_q counts bits already placed on MISO
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        miso_d = miso_q;
        if (clear_i) begin
            sr_d   = '0;
            cnt_d  = '0;
            miso_d = 1'b0;
        end else if (load_i) begin
            sr_d   = {data_i[DATA_W-2:0], 1'b0};
            cnt_d  = CNT_W'(1);
            miso_d = data_i[DATA_W-1];
        end else if (shift_i) begin
            sr_d   = {sr_q[DATA_W-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
            miso_d = sr_q[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            miso_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;
    assign done_o = (cnt_q == CNT_W'(DATA_W));

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave front-end for the single-port RAM controller.
// One frame per SS_n assertion: {opcode[1:0], payload[DATA_W-1:0]}, MSB first.
//   clk, rst_n : clock, synchronous active-low reset
//   SS_n       : active-low slave select (frame boundary)
//   MOSI       : serial input, sampled one bit per rising edge
//   MISO       : serial read-data output, 0 when not transmitting
//   rx_data    : last complete received word (held between frames)
//   rx_valid   : one-cycle pulse, rx_data updated
//   tx_data    : read word from RAM
//   tx_valid   : tx_data valid, only looked at in TX_WAIT
//   frame_err  : one-cycle pulse, SS_n rose before the frame completed
module spi_slave_param #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_err
);
    import spi_slave_pkg::*;

    localparam int RX_W  = DATA_W + 2;
    localparam int CNT_W = $clog2(RX_W + 1);

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [RX_W-2:0]   sr_q,        sr_d;
    logic [RX_W-1:0]   rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              pend_q,      pend_d;

    logic ser_load, ser_shift, ser_clear, ser_done;

    spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ser_load),
        .shift_i (ser_shift),
        .clear_i (ser_clear),
        .data_i  (tx_data),
        .miso_o  (MISO),
        .done_o  (ser_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        pend_d      = pend_q;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;
        ser_clear   = 1'b0;

        if (SS_n) begin
            // Deselect ends any frame; only an unfinished one is an error.
            state_d = IDLE;
            if (state_q != IDLE && state_q != DONE) begin
                frame_err_d = 1'b1;
                ser_clear   = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    cnt_d   = '0;
                end
                CHK_CMD: begin
                    sr_d  = {sr_q[RX_W-3:0], MOSI};
                    cnt_d = CNT_W'(1);
                    if (MOSI == OP_WR_ADDR[1])
                        state_d = WRITE;
                    else if (pend_q)
                        state_d = READ_DATA;
                    else
                        state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    sr_d = {sr_q[RX_W-3:0], MOSI};
                    if (cnt_q == CNT_W'(RX_W - 1)) begin
                        rx_data_d  = {sr_q, MOSI};
                        rx_valid_d = 1'b1;
                        cnt_d      = CNT_W'(RX_W);
                        if (state_q == READ_DATA) begin
                            state_d = TX_WAIT;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = DONE;
                            if (state_q == READ_ADD)
                                pend_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                TX_WAIT: begin
                    if (tx_valid) begin
                        ser_load = 1'b1;
                        state_d  = TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (ser_done) begin
                        ser_clear = 1'b1;
                        state_d   = DONE;
                    end else begin
                        ser_shift = 1'b1;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            pend_q      <= pend_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param with DATA_W=8 and DATA_W=16 instances.
module tb_spi_slave_param;

    logic clk = 1'b0;
    logic rst_n;

    logic        ss8, mosi8, miso8, rxv8, txv8, fe8;
    logic [9:0]  rxd8;
    logic [7:0]  txd8;

    logic        ss16, mosi16, miso16, rxv16, txv16, fe16;
    logic [17:0] rxd16;
    logic [15:0] txd16;

    int checks = 0;
    int errors = 0;
    int fe_cnt8 = 0, fe_cnt16 = 0, mh_cnt8 = 0, mh_cnt16 = 0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss8), .MOSI(mosi8), .MISO(miso8),
        .rx_data(rxd8), .rx_valid(rxv8), .tx_data(txd8), .tx_valid(txv8),
        .frame_err(fe8)
    );

    spi_slave_param #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
        .rx_data(rxd16), .rx_valid(rxv16), .tx_data(txd16), .tx_valid(txv16),
        .frame_err(fe16)
    );

    // Running counts of frame_err pulses and MISO-high cycles per instance
    always @(posedge clk) begin
        if (fe8)    fe_cnt8++;
        if (fe16)   fe_cnt16++;
        if (miso8)  mh_cnt8++;
        if (miso16) mh_cnt16++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rxd(input int sel);
        return (sel == 16) ? 32'(rxd16) : 32'(rxd8);
    endfunction
    function automatic logic rxv(input int sel);
        return (sel == 16) ? rxv16 : rxv8;
    endfunction
    function automatic logic miso(input int sel);
        return (sel == 16) ? miso16 : miso8;
    endfunction
    function automatic logic fe(input int sel);
        return (sel == 16) ? fe16 : fe8;
    endfunction
    function automatic int fe_cnt(input int sel);
        return (sel == 16) ? fe_cnt16 : fe_cnt8;
    endfunction
    function automatic int mh_cnt(input int sel);
        return (sel == 16) ? mh_cnt16 : mh_cnt8;
    endfunction

    task automatic drive(input int sel, input logic ss, input logic m);
        if (sel == 16) begin ss16 = ss; mosi16 = m; end
        else           begin ss8  = ss; mosi8  = m; end
    endtask

    task automatic set_tx(input int sel, input logic v, input logic [15:0] d);
        if (sel == 16) begin txv16 = v; txd16 = d; end
        else           begin txv8  = v; txd8  = d[7:0]; end
    endtask

    // Lower SS_n, then present the first cnt bits of an n-bit word MSB first
    task automatic send_bits(input int sel, input logic [31:0] word, input int n, input int cnt);
        @(negedge clk) drive(sel, 1'b0, 1'b0);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk) drive(sel, 1'b0, word[n-1-i]);
        end
    endtask

    task automatic full_frame(input int sel, input logic [31:0] word, input int n, input string tag);
        send_bits(sel, word, n, n);
        check({tag, "_rxv_early"}, 32'(rxv(sel)), 32'd0);
        @(negedge clk);
        check({tag, "_rxv"}, 32'(rxv(sel)), 32'd1);
        check({tag, "_rxd"}, rxd(sel), word);
        @(negedge clk);
        check({tag, "_rxv_pulse"}, 32'(rxv(sel)), 32'd0);
    endtask

    task automatic end_frame(input int sel);
        @(negedge clk) drive(sel, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    // Wait three cycles in TX_WAIT, present the read word, then check each MISO bit
    task automatic transmit(input int sel, input logic [15:0] d, input int w, input string tag);
        int mh0;
        mh0 = mh_cnt(sel);
        repeat (3) @(negedge clk);
        check({tag, "_miso_wait"}, 32'(mh_cnt(sel) - mh0), 32'd0);
        set_tx(sel, 1'b1, d);
        for (int i = 0; i < w; i++) begin
            @(negedge clk) set_tx(sel, 1'b0, 16'h0);
            check($sformatf("%s_bit%0d", tag, i), 32'(miso(sel)), 32'(d[w-1-i]));
        end
        @(negedge clk);
        check({tag, "_miso_after"}, 32'(miso(sel)), 32'd0);
    endtask

    initial begin
        int fe0, mh0;
        rst_n = 1'b0;
        drive(8, 1'b1, 1'b0);
        drive(16, 1'b1, 1'b0);
        set_tx(8, 1'b0, 16'h0);
        set_tx(16, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        check("rst_rxd8", rxd(8), 32'h0);
        check("rst_rxv8", 32'(rxv8), 32'd0);
        check("rst_miso8", 32'(miso8), 32'd0);
        check("rst_fe8", 32'(fe8), 32'd0);
        check("rst_rxd16", rxd(16), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address 00_1010_0101
        fe0 = fe_cnt(8); mh0 = mh_cnt(8);
        full_frame(8, 32'h0A5, 10, "wa");
        end_frame(8);
        check("wa_miso", 32'(mh_cnt(8) - mh0), 32'd0);
        check("wa_fe", 32'(fe_cnt(8) - fe0), 32'd0);

        // Read address then read data with 8'hC3
        full_frame(8, 32'h203, 10, "ra");
        end_frame(8);
        full_frame(8, 32'h300, 10, "rd");
        transmit(8, 16'h00C3, 8, "tx8");
        fe0 = fe_cnt(8);
        end_frame(8);
        check("tx8_fe", 32'(fe_cnt(8) - fe0), 32'd0);

        // Abort: pending set by a read address, then a write cut short after 5 bits
        full_frame(8, 32'h2A5, 10, "ra2");
        end_frame(8);
        send_bits(8, 32'h155, 10, 5);
        @(negedge clk) drive(8, 1'b1, 1'b0);
        @(negedge clk);
        check("ab_fe", 32'(fe8), 32'd1);
        check("ab_rxv", 32'(rxv8), 32'd0);
        check("ab_rxd", rxd(8), 32'h2A5);
        @(negedge clk);
        check("ab_fe_pulse", 32'(fe8), 32'd0);
        // Pending survives the abort, so this mode-1 frame transmits
        full_frame(8, 32'h311, 10, "rd2");
        transmit(8, 16'h005A, 8, "tx8b");
        end_frame(8);

        // Pending now clear: mode-1 frame routes to READ_ADD, no transmit
        mh0 = mh_cnt(8); fe0 = fe_cnt(8);
        full_frame(8, 32'h300, 10, "noaddr");
        set_tx(8, 1'b1, 16'h00FF);
        repeat (4) @(negedge clk);
        set_tx(8, 1'b0, 16'h0);
        end_frame(8);
        check("noaddr_miso", 32'(mh_cnt(8) - mh0), 32'd0);
        check("noaddr_fe", 32'(fe_cnt(8) - fe0), 32'd0);

        // Reset during transmit: pending is 1 now, so 11 frame goes to TX
        full_frame(8, 32'h3FF, 10, "rd3");
        @(negedge clk) set_tx(8, 1'b1, 16'h00FF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) set_tx(8, 1'b0, 16'h0);
        end
        check("rstx_miso_pre", 32'(miso8), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstx_miso", 32'(miso8), 32'd0);
        check("rstx_rxd", rxd(8), 32'h0);
        rst_n = 1'b1;
        drive(8, 1'b1, 1'b0);
        drive(16, 1'b1, 1'b0);
        @(negedge clk);
        check("rstx_fe", 32'(fe8), 32'd0);
        full_frame(8, 32'h155, 10, "post");
        end_frame(8);

        // DATA_W=16: write data 01_BEEF, then a read returning 16'h8001
        full_frame(16, 32'h1BEEF, 18, "w16");
        end_frame(16);
        full_frame(16, 32'h20000, 18, "ra16");
        end_frame(16);
        full_frame(16, 32'h30000, 18, "rd16");
        transmit(16, 16'h8001, 16, "tx16");
        end_frame(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
